regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-port physical register file for the out-of-order core, with a per-register ready (scoreboard) bit.
- Read, write and allocate port counts are parameters. Register 0 is hardwired zero.
- Sits between rename/dispatch (allocate and read-ready queries) and the execution writeback ports.

Parameters:
- WIDTH, 6: address bits; depth = 2**WIDTH registers.
- DATA, 32: data width in bits.
- NR, 8: number of read ports.
- NW, 4: number of write ports.
- NA, 2: number of allocate ports; each clears a ready bit.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_raddr  in  NR*WIDTH  read addresses; port k uses bits [k*WIDTH +: WIDTH].
- o_rdata  out  NR*DATA  read data, combinational.
- o_rready  out  NR  ready bit of each read address, combinational.
- i_we  in  NW  write enables.
- i_waddr  in  NW*WIDTH  write addresses.
- i_wdata  in  NW*DATA  write data.
- i_alloc  in  NA  allocate enables.
- i_aaddr  in  NA*WIDTH  allocate addresses.
- o_nready  out  WIDTH+1  count of ready registers, registered.

Behaviour:
- Reset (async, i_rst_n=0):
  - all data words = 0; all ready bits = 1.
  - o_nready = 2**WIDTH.
  - Combinational outputs follow the reset contents immediately.
- Read:
  - o_rdata[k] = data[raddr k]; o_rready[k] = ready[raddr k].
  - Address 0 always returns data 0, ready 1.
- Write: at the rising edge, for each port j with i_we[j]=1 and waddr != 0: data <= wdata and ready <= 1.
  - Writes to address 0 are ignored.
  - Same address on several write ports in one cycle: highest-index port wins, for both data and ready.
- Allocate: at the rising edge, for each port a with i_alloc[a]=1 and aaddr != 0: ready <= 0. Data is unchanged.
  - Allocate to address 0 is ignored.
- Write and allocate to the same address in one cycle: allocate wins (ready = 0), but the data write still happens.
  - This case marks a new producer for the register.
- Duplicate allocate addresses in one cycle: single clear; the count is decremented once.
- o_nready is updated every edge to the ready-bit population count of the next state, so it is exact with one cycle of latency.
- Reads without the optional feature see only state committed at the previous edge; a same-cycle write is not visible until the next cycle.
- Reset asserted mid-operation overrides all pending writes and allocates.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If raddr k matches an enabled write port this cycle (address != 0), o_rdata[k] = that port's wdata (highest matching index wins) and o_rready[k] = 1.
  - A same-cycle allocate does not suppress the forwarded ready.
- Undefined: no forwarding; read data appears one cycle after the write edge.

Decomposition:
- Shared package regfile_pkg holds:
  - default DATA and WIDTH constants;
  - the slice helper macro/function for flattened port vectors;
  - the ZERO_REG = 0 constant.
- One sub-module: regfile_popcnt, a parametrised population counter (N inputs, clog2(N)+1 output) used for o_nready.

Test Plan:
- Reset with i_rst_n=0 mid-cycle → all o_rdata=0, all o_rready=1, o_nready=64 (WIDTH=6) asynchronously.
- Allocate addr 5, next cycle read port 0 raddr=5 → o_rready[0]=0, o_nready=63. Then write port 2 addr 5 data 0xDEADBEEF → next cycle o_rdata[0]=0xDEADBEEF, o_rready[0]=1, o_nready=64.
- Write ports 0 and 3 both addr 7, data 0x11 and 0x33 → next cycle read addr 7 = 0x33.
- Write addr 0 data 0xFFFFFFFF plus allocate addr 0 → read addr 0 gives 0, ready 1, o_nready unchanged.
- Same cycle: write addr 9 data 0xA5 and allocate addr 9 → next cycle data 0xA5, ready 0, o_nready=63.
- REGFILE_BYPASS_EN on, write addr 12 data 0x1234 while reading addr 12 → same cycle o_rdata=0x1234, o_rready=1. With the macro off → old value until the next edge.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : regfile_pkg                                                  |
// | Description : Shared constants and flattened-port slice helper for the    |
// |               multi-port physical register file.                           |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+

`ifndef REGFILE_PKG_SV
`define REGFILE_PKG_SV

// Port k of a flattened vector of w-bit fields.
`define RF_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]

package regfile_pkg;
    localparam int DEFAULT_WIDTH = 6;
    localparam int DEFAULT_DATA  = 32;
    localparam int ZERO_REG      = 0;
endpackage

`endif

`default_nettype wire

// File: rtl/regfile_popcnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : regfile_popcnt                                               |
// | Description : Parametrised population counter, N inputs, clog2(N)+1 bits. |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+

module regfile_popcnt
    import regfile_pkg::*;
#(
    parameter int N = 2**DEFAULT_WIDTH
) (
    input  logic [N-1:0]       i_bits,
    output logic [$clog2(N):0] o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < N; i++) begin
            o_count = o_count + {{$clog2(N){1'b0}}, i_bits[i]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : regfile_mp                                                   |
// | Description : Multi-port physical register file with per-register ready   |
// |               bits. Optional macro REGFILE_BYPASS_EN adds write-to-read   |
// |               forwarding.                                                  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+

module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DATA  = DEFAULT_DATA,
    parameter int NR    = 8,
    parameter int NW    = 4,
    parameter int NA    = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [NR*WIDTH-1:0] i_raddr,
    output logic [NR*DATA-1:0]  o_rdata,
    output logic [NR-1:0]       o_rready,
    input  logic [NW-1:0]       i_we,
    input  logic [NW*WIDTH-1:0] i_waddr,
    input  logic [NW*DATA-1:0]  i_wdata,
    input  logic [NA-1:0]       i_alloc,
    input  logic [NA*WIDTH-1:0] i_aaddr,
    output logic [WIDTH:0]      o_nready
);

    localparam int               c_depth     = 2**WIDTH;
    localparam logic [WIDTH-1:0] c_zero_addr = WIDTH'(ZERO_REG);

    logic [DATA-1:0]    r_data [c_depth];
    logic [c_depth-1:0] r_ready;
    logic [c_depth-1:0] w_ready_nxt;
    logic [WIDTH:0]     r_nready;
    logic [WIDTH:0]     w_nready_nxt;

    // Allocates are applied after writes so a new producer clears ready.
    always_comb begin
        w_ready_nxt = r_ready;
        for (int j = 0; j < NW; j++) begin
            if (i_we[j] && (`RF_SLICE(i_waddr, j, WIDTH) != c_zero_addr)) begin
                w_ready_nxt[`RF_SLICE(i_waddr, j, WIDTH)] = 1'b1;
            end
        end
        for (int a = 0; a < NA; a++) begin
            if (i_alloc[a] && (`RF_SLICE(i_aaddr, a, WIDTH) != c_zero_addr)) begin
                w_ready_nxt[`RF_SLICE(i_aaddr, a, WIDTH)] = 1'b0;
            end
        end
        w_ready_nxt[ZERO_REG] = 1'b1;
    end

    regfile_popcnt #(
        .N (c_depth)
    ) u_popcnt (
        .i_bits  (w_ready_nxt),
        .o_count (w_nready_nxt)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ready  <= '1;
            r_nready <= (WIDTH+1)'(c_depth);
        end else begin
            r_ready  <= w_ready_nxt;
            r_nready <= w_nready_nxt;
        end
    end

    // Ascending port loop: the last non-blocking update (highest port) wins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < c_depth; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            for (int j = 0; j < NW; j++) begin
                if (i_we[j] && (`RF_SLICE(i_waddr, j, WIDTH) != c_zero_addr)) begin
                    r_data[`RF_SLICE(i_waddr, j, WIDTH)] <= `RF_SLICE(i_wdata, j, DATA);
                end
            end
        end
    end

    assign o_nready = r_nready;

    generate
        for (genvar k = 0; k < NR; k++) begin : g_rd
            logic [WIDTH-1:0] w_ra;
            logic [DATA-1:0]  w_rd;
            logic             w_rr;

            assign w_ra = `RF_SLICE(i_raddr, k, WIDTH);

            always_comb begin
                w_rd = r_data[w_ra];
                w_rr = r_ready[w_ra];
`ifdef REGFILE_BYPASS_EN
                for (int j = 0; j < NW; j++) begin
                    if (i_we[j] && (`RF_SLICE(i_waddr, j, WIDTH) != c_zero_addr) &&
                        (`RF_SLICE(i_waddr, j, WIDTH) == w_ra)) begin
                        w_rd = `RF_SLICE(i_wdata, j, DATA);
                        w_rr = 1'b1;
                    end
                end
`endif
            end

            assign `RF_SLICE(o_rdata, k, DATA) = w_rd;
            assign o_rready[k] = w_rr;
        end
    endgenerate

endmodule

`default_nettype wire
